// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: optional identity init of the S-box RAM, then the full
// KSA swap loop driving a single-port synchronous RAM (one-cycle read latency).
module ksa_engine #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   skip_init,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [ADDR_W-1:0]      mem_wrdata,
    output logic                   mem_wren,
    input  logic [ADDR_W-1:0]      mem_rddata,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned       KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle, StInit, StRdI, StCalcJ, StRdJ, StWrJ, StWrI, StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d;
    logic [ADDR_W-1:0]      si_q, si_d, sj_q, sj_d;
    logic [KIDX_W-1:0]      kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [ADDR_W-1:0]      kb;
    logic                   i_last;

    assign i_last = (i_q == {ADDR_W{1'b1}});

    // Byte 0 is the most significant byte of the key; low ADDR_W bits of it are used.
    always_comb begin
        kb = '0;
        for (int unsigned b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KIDX_W'(b)) kb = key_q[8*(KEY_BYTES-1-b) +: ADDR_W];
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        kidx_d     = kidx_q;
        key_d      = key_q;
        mem_addr   = '0;
        mem_wrdata = '0;
        mem_wren   = 1'b0;
        busy       = (state_q != StIdle);
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = skip_init ? StRdI : StInit;
                end
            end
            StInit: begin
                mem_wren   = 1'b1;
                mem_addr   = i_q;
                mem_wrdata = i_q;
                i_d        = i_q + 1'b1;
                if (i_last) state_d = StRdI;
            end
            StRdI: begin
                mem_addr = i_q;
                state_d  = StCalcJ;
            end
            StCalcJ: begin
                mem_addr = i_q;
                si_d     = mem_rddata;
                j_d      = j_q + mem_rddata + kb;
                state_d  = StRdJ;
            end
            StRdJ: begin
                mem_addr = j_q;
                state_d  = StWrJ;
            end
            // S[j] is captured before either write, so i == j stores si twice.
            StWrJ: begin
                sj_d       = mem_rddata;
                mem_wren   = 1'b1;
                mem_addr   = j_q;
                mem_wrdata = si_q;
                state_d    = StWrI;
            end
            StWrI: begin
                mem_wren   = 1'b1;
                mem_addr   = i_q;
                mem_wrdata = sj_q;
                i_d        = i_q + 1'b1;
                kidx_d     = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
                state_d    = i_last ? StDone : StRdI;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            kidx_q  <= '0;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            kidx_q  <= kidx_d;
            key_q   <= key_d;
        end
    end

endmodule

// File: doc/ksa_engine.md
# ksa_engine

Self-contained, parametrised RC4 key-scheduling engine: optionally initialises an S-box RAM to the identity permutation, then runs the full KSA swap loop with the key-byte selection and j arithmetic done internally. It drives a single-port synchronous RAM directly and hands a one-cycle completion strobe to the top-level cipher sequencer. It generalises the earlier control-only shuffle FSM in S-box size, key length and init mode.

## Interface
- ADDR_W, 8, S-box index/data width; S-box depth N = 2^ADDR_W; legal 4..8
- KEY_BYTES, 3, key length in bytes; legal 1..32
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a run; sampled only in IDLE
- skip_init  in  1  1 = skip identity-init phase; latched with start
- key  in  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8]; latched with start
- mem_addr  out  ADDR_W  RAM address
- mem_wrdata  out  ADDR_W  RAM write data
- mem_wren  out  1  RAM write enable
- mem_rddata  in  ADDR_W  RAM read data, valid the cycle after mem_addr is presented with mem_wren=0
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse in DONE state

## Operation
- Registers: i, j (ADDR_W bits, wrap mod N), kidx (0..KEY_BYTES-1, wraps at KEY_BYTES-1; no divider), si, sj, key_q, skip_q.
- Key byte kb = key_q byte kidx, truncated to its low ADDR_W bits when ADDR_W < 8.
- States:
  - IDLE: outputs idle. On start: latch key/skip_init; clear i, j, kidx; go to INIT, or to RD_I if skip_init.
  - INIT: mem_wren=1, mem_addr=i, mem_wrdata=i; i++. After writing i=N-1 (i wraps to 0), go to RD_I.
  - RD_I: mem_addr=i, read.
  - CALC_J: si <= mem_rddata; j <= j + mem_rddata + kb (mod N).
  - RD_J: mem_addr=j, read.
  - WR_J: sj <= mem_rddata; write mem[j] = si.
  - WR_I: write mem[i] = sj; i++; kidx++ (wrapping). If i was N-1, go to DONE, else to RD_I.
  - DONE: done=1 for one cycle, then IDLE.
- i == j: sj is read before either write, so sj = si and both writes store the same value; the permutation is preserved.
- start while busy is ignored. key and skip_init changes after the sampling edge have no effect.
- mem_addr and mem_wrdata are 0 in IDLE and DONE. mem_wren is high only in INIT, WR_J and WR_I.

## Timing
- Reset (async assert): state=IDLE. busy, done, mem_wren, mem_addr and mem_wrdata are all 0. Internal registers are cleared.
- Reset mid-run aborts immediately. RAM contents are then undefined (partial). The next start performs a complete fresh run.
- Phase lengths:
  - INIT: N cycles.
  - Shuffle: 5 cycles per iteration, N iterations.
  - DONE: 1 cycle.
- With start sampled at edge k, done is high in cycle k+6N+1, or k+5N+1 with skip_init. busy is high for exactly 6N+1 (or 5N+1) cycles.
- A new start is accepted on the first IDLE cycle after DONE.
- Read data is captured exactly one cycle after the address. No other RAM latency is supported.

## Test plan
- Reset: hold rst_n=0 mid-clock, asynchronously -> busy=0, done=0, mem_wren=0, mem_addr=0 without a clock edge.
- ADDR_W=8, KEY_BYTES=3, key=24'h4B6579, skip_init=0:
  - INIT writes mem[n]=n for n=0..255 on 256 consecutive cycles.
  - First shuffle iteration writes mem[0x4B]=0x00, then mem[0x00]=0x4B.
  - Final 256-byte RAM equals the software KSA model.
  - done pulses at cycle k+1537.
- skip_init=1 with RAM preloaded to identity, same key -> identical final RAM to the previous case; done at cycle k+1281; no INIT writes observed.
- Pulse start repeatedly and toggle key mid-run -> single run; result matches the key latched at the first start; done exactly once.
- Assert rst_n at iteration 100, then restart with key=24'h010203 -> final RAM matches the model for 24'h010203.
- ADDR_W=4, KEY_BYTES=1, key=8'h00 -> iteration 0 has i=j=0 and writes 0 twice to mem[0]; final 16-entry RAM matches the model (values mod 16); done at k+97.
